ps2_key_event_ctrl: RTL
=======================

Name: ps2_key_event_ctrl

Overview:
- Sequences the raw PS/2 scan-code byte stream into complete key events; sits directly after the PS/2 receiver.
- Consumes the receiver's one-cycle byte strobe and decodes the E0 (extended), F0 (break) and E1 (Pause) prefix sequences.
- Queues decoded make/break events in a small first-word-fall-through FIFO for downstream consumers (display, UART, game logic).

Parameters:
- DEPTH, 8, event FIFO depth; power of two, minimum 2.
- TIMEOUT_CYCLES, 2000000, clk cycles allowed between prefix bytes before the sequence is abandoned (20 ms at 100 MHz).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- byte_in  in  8  scan-code byte from the receiver (low byte of its keycode output).
- byte_valid  in  1  one-cycle strobe; byte_in is valid when high.
- evt_ready  in  1  consumer accepts the head event when high together with evt_valid.
- clr_flags  in  1  clears overflow and err.
- evt_valid  out  1  FIFO non-empty.
- evt_code  out  8  head event scan code.
- evt_ext  out  1  head event had an E0 prefix.
- evt_brk  out  1  head event is a release (F0 seen).
- evt_count  out  $clog2(DEPTH)+1  FIFO occupancy.
- overflow  out  1  sticky; an event was dropped because the FIFO was full.
- err  out  1  sticky; timeout or device error byte seen.

Behaviour:
- Reset (rst_n=0 at posedge):
  - FSM to IDLE; FIFO emptied.
  - All outputs 0: evt_valid, evt_code, evt_ext, evt_brk, evt_count, overflow, err.
  - Timeout counter cleared. Reset mid-sequence discards any partial prefix.
- FSM states: IDLE, EXT, BRK, EXT_BRK, PAUSE.
- FSM transitions, evaluated only on cycles with byte_valid=1:
  - IDLE:
    - E0 -> EXT; F0 -> BRK.
    - E1 -> PAUSE, skip count loaded with 7.
    - AA, FA, EE: ignored (BAT/ACK/echo).
    - 00, FF, FC, FD, FE: set err, stay in IDLE.
    - Any other byte: emit {ext=0, brk=0, code}.
  - EXT: F0 -> EXT_BRK; E0 -> stay; any other byte: emit {1,0,code}, -> IDLE.
  - BRK: emit {0,1,code}, -> IDLE.
  - EXT_BRK: emit {1,1,code}, -> IDLE.
  - PAUSE: decrement the skip count per byte. When it reaches 0, emit {0,0,8'hE1} and -> IDLE. The Pause key makes exactly one event.
- Timeout:
  - In any state other than IDLE, a counter increments each cycle without byte_valid and clears on byte_valid.
  - At TIMEOUT_CYCLES: -> IDLE, set err, emit nothing.
- Emit latency:
  - An event is pushed on the posedge that samples the final byte_valid.
  - evt_valid is visible the next cycle when the FIFO was empty (1-cycle latency).
- FIFO:
  - First-word-fall-through; evt_* show the head entry and are stable while evt_valid=1 and evt_ready=0.
  - Pop on evt_valid & evt_ready.
  - Push when full with no pop: event dropped, overflow set, contents unchanged.
  - Push and pop in the same cycle when full: both succeed, count unchanged.
  - Pop when empty: ignored.
  - Read/write pointers wrap modulo DEPTH.
- Sticky flags:
  - clr_flags clears overflow and err.
  - A set and a clear in the same cycle: set wins.
- byte_valid is assumed to be at most one cycle wide per byte; back-to-back strobes on consecutive cycles are each processed.

Optional Feature:
- Macro: PS2_REPEAT_FILTER_EN.
- Defined:
  - A 256-entry held-key bitmap, separate for ext=0 and ext=1 (512 bits total), records keys currently down.
  - A make event for a key already held is suppressed (typematic repeat): no FIFO push and no flag change.
  - A break event clears the bit and is always pushed.
  - Reset clears the bitmap. Timeout and error leave it untouched.
- Undefined: every make, repeats included, is pushed; no bitmap logic is instantiated.

Test Plan:
- Plain make/break: bytes 1C, F0, 1C with evt_ready=1 -> events {0,0,1C} then {0,1,1C}; evt_valid high one cycle after each final byte.
- Extended: E0 75, E0 F0 75 -> {1,0,75}, {1,1,75}; BAT byte AA interleaved before them -> no event, err stays 0.
- Pause: E1 14 77 E1 F0 14 F0 77 -> exactly one event {0,0,E1}, FSM back in IDLE.
- Overflow: DEPTH=8, evt_ready=0, 9 make codes 15..1D -> evt_count=8, overflow=1, head=15. Then one pop plus a push of 1E in the same cycle -> count stays 8. clr_flags -> overflow=0.
- Timeout: TIMEOUT_CYCLES=50, byte E0 then 50 idle cycles -> err=1, state IDLE; following byte 1C -> {0,0,1C}, not extended.
- Repeat filter (macro defined): 1C 1C 1C F0 1C -> events {0,0,1C}, {0,1,1C} only. Macro undefined -> four events.

Source files
------------

// File: rtl/ps2_key_event_ctrl_if.sv
// Byte-strobe input and event-output bundle of the PS/2 key event controller.
// master drives bytes and evt_ready; slave (the controller) returns the FIFO head.
interface ps2_key_event_ctrl_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       evt_ready;
  logic       evt_valid;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_brk;

  modport master (
    output byte_in, byte_valid, evt_ready,
    input  evt_valid, evt_code, evt_ext, evt_brk
  );

  modport slave (
    input  byte_in, byte_valid, evt_ready,
    output evt_valid, evt_code, evt_ext, evt_brk
  );
endinterface

// File: rtl/ps2_key_event_ctrl.sv
// PS/2 scan-code sequencer: E0/F0/E1 prefixes to make/break events in a FWFT FIFO.
// Event pushed on the final byte's edge, visible next cycle; full FIFO drops and sets overflow. PS2_REPEAT_FILTER_EN adds typematic filtering.
module ps2_key_event_ctrl #(
  parameter int DEPTH          = 8,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  ps2_key_event_ctrl_if.slave      bus,
  input  logic                     clr_flags,
  output logic [$clog2(DEPTH):0]   evt_count,
  output logic                     overflow,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_t;

  state_t        state, state_nxt;
  logic [2:0]    skip, skip_nxt;
  logic [TW-1:0] tmr;
  logic          timeout;

  logic          emit, e_ext, e_brk, err_set;
  logic [7:0]    e_code;
  logic          push_req;

  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          nonempty, full, pop, push, drop;

  assign timeout = (state != IDLE) && !bus.byte_valid && (tmr == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      skip  <= '0;
      tmr   <= '0;
    end else begin
      state <= state_nxt;
      skip  <= skip_nxt;
      if (state == IDLE || bus.byte_valid || timeout)
        tmr <= '0;
      else
        tmr <= tmr + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    skip_nxt  = skip;
    emit      = 1'b0;
    e_ext     = 1'b0;
    e_brk     = 1'b0;
    e_code    = bus.byte_in;
    err_set   = 1'b0;
    if (bus.byte_valid) begin
      case (state)
        IDLE: begin
          case (bus.byte_in)
            8'hE0: state_nxt = EXT;
            8'hF0: state_nxt = BRK;
            8'hE1: begin
              state_nxt = PAUSE;
              skip_nxt  = 3'd7;
            end
            8'hAA, 8'hFA, 8'hEE: ;
            8'h00, 8'hFF, 8'hFC, 8'hFD, 8'hFE: err_set = 1'b1;
            default: emit = 1'b1;
          endcase
        end
        EXT: begin
          if (bus.byte_in == 8'hF0) begin
            state_nxt = EXT_BRK;
          end else if (bus.byte_in != 8'hE0) begin
            emit      = 1'b1;
            e_ext     = 1'b1;
            state_nxt = IDLE;
          end
        end
        BRK: begin
          emit      = 1'b1;
          e_brk     = 1'b1;
          state_nxt = IDLE;
        end
        EXT_BRK: begin
          emit      = 1'b1;
          e_ext     = 1'b1;
          e_brk     = 1'b1;
          state_nxt = IDLE;
        end
        PAUSE: begin
          // The remaining seven Pause bytes are swallowed; one event marks the key.
          skip_nxt = skip - 3'd1;
          if (skip == 3'd1) begin
            emit      = 1'b1;
            e_code    = 8'hE1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end else if (timeout) begin
      state_nxt = IDLE;
      err_set   = 1'b1;
    end
  end

`ifdef PS2_REPEAT_FILTER_EN
  logic [511:0] held;
  logic [8:0]   hidx;

  assign hidx     = {e_ext, e_code};
  assign push_req = emit && (e_brk || !held[hidx]);

  always_ff @(posedge clk) begin
    if (!rst_n)
      held <= '0;
    else if (emit)
      held[hidx] <= !e_brk;
  end
`else
  assign push_req = emit;
`endif

  assign nonempty = (cnt != '0);
  assign full     = (cnt == (AW+1)'(DEPTH));
  assign pop      = nonempty && bus.evt_ready;
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= {e_ext, e_brk, e_code};
  end

  // Head fields are forced to zero while empty so stale storage never leaks out.
  assign bus.evt_valid = nonempty;
  assign bus.evt_ext   = nonempty ? mem[rp][9]   : 1'b0;
  assign bus.evt_brk   = nonempty ? mem[rp][8]   : 1'b0;
  assign bus.evt_code  = nonempty ? mem[rp][7:0] : 8'h00;
  assign evt_count     = cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (drop)           overflow <= 1'b1;
      else if (clr_flags) overflow <= 1'b0;
      if (err_set)        err <= 1'b1;
      else if (clr_flags) err <= 1'b0;
    end
  end

endmodule
